program_loader: RTL
===================

Name: program_loader

Overview:
- Writes a program image into main memory before the CPU starts; it is the write side of the CPU's instruction-fetch read path.
- Receives a byte stream on a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one main-memory write per word at consecutive addresses starting from BASE_ADDR.
- Holds the CPU in reset (cpu_hold) until the image has been written, then releases it.

Parameters:
- DEPTH, 2048: main-memory depth in words; the maximum legal word count.
- BASE_ADDR, 0: word address of the first instruction written.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle. A byte transfers when byte_valid && byte_ready.
- mem_waddr  output  32  main-memory write address.
- mem_wdata  output  32  main-memory write data.
- mem_wen  output  1  main-memory write enable, one cycle per word.
- cpu_hold  output  1  high holds the CPU in reset.
- done  output  1  load completed successfully (sticky).
- error  output  1  word count exceeded DEPTH (sticky).

Behaviour:
- Reset (rst=0, asynchronous):
  - State = HDR.
  - byte_ready=0, mem_wen=0, mem_waddr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, done=0, error=0.
  - Byte counter, word count and address counter cleared.
  - Asserting reset mid-load aborts the load; the partially written memory contents are not restored.
- Stream format:
  - 4-byte word count N, little-endian (first byte = bits 7:0).
  - Then N words of 4 bytes each, little-endian.
- Byte handshake:
  - byte_ready is registered: high in HDR and DATA, low in every other state.
  - byte_valid may stay high indefinitely; no byte is lost or duplicated.
- States:
  - HDR: accept 4 bytes into the count register. When the 4th byte is accepted:
    - N=0 → DONE.
    - N>DEPTH → ERR.
    - otherwise → DATA.
  - DATA: accept 4 bytes into the word shift register. When the 4th byte is accepted → WRITE.
  - WRITE (exactly 1 cycle):
    - mem_wen=1, mem_wdata = assembled word, mem_waddr = BASE_ADDR + index.
    - byte_ready=0.
    - The index increments on exit.
    - If index+1 == N → DONE, else → DATA.
  - DONE: cpu_hold=0, done=1, byte_ready=0. Terminal until reset.
  - ERR: error=1, cpu_hold=1, byte_ready=0. Terminal until reset.
- Latency:
  - The 4th byte of a word is accepted in cycle t; mem_wen=1 in cycle t+1; byte_ready is high again in cycle t+2.
  - Steady-state throughput is one word per 5 cycles.
  - cpu_hold falls in the cycle after the final WRITE cycle.
- Outputs:
  - mem_wen=0 outside WRITE.
  - mem_waddr and mem_wdata hold their last values outside WRITE.
- Arithmetic:
  - The index counter is 32 bits.
  - N==DEPTH is legal; the last address written is BASE_ADDR+DEPTH-1.
  - No wrap-around can occur because N≤DEPTH is enforced.
- No byte is accepted once the state is DONE or ERR; further bytes stall at the source.

Test Plan:
- Basic load: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE, with byte_valid held high.
  - Writes 0x12345678 @0, then 0xDEADBEEF @1.
  - mem_wen high exactly 2 cycles, 5 cycles apart.
  - cpu_hold=0 and done=1 one cycle after the second write.
- Zero count: bytes 00 00 00 00 → DONE with no mem_wen pulse; byte_ready low afterwards.
- Overflow: count bytes 01 08 00 00 (0x801 = DEPTH+1) → error=1, cpu_hold stays 1, no writes, byte_ready stays 0.
- Gappy source: N=1, byte_valid toggled 1/0 randomly with data 11 22 33 44 → exactly one write of 0x44332211 @BASE_ADDR.
- Reset mid-load: assert rst low after 2 of 3 words have been written.
  - All outputs return to reset values immediately (asynchronously).
  - A fresh N=1 stream then writes its word @BASE_ADDR.
- Full depth: N=2048 with incrementing word data → last write at address 2047; done=1; error=0.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: turns a little-endian byte stream (word count, then words) into
// consecutive main-memory writes and holds the CPU in reset until the image is in place.
module program_loader #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] index_q, index_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        wen_q, wen_d;
  logic        take;
  logic [31:0] shifted;

  assign take    = byte_valid && ready_q;
  assign shifted = {byte_data, shift_q[31:8]};

  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    count_d = count_q;
    shift_d = shift_q;
    index_d = index_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      HDR: begin
        if (take) begin
          count_d = {byte_data, count_q[31:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (count_d == 32'd0) begin
              state_d = DONE;
            end else if (count_d > 32'(DEPTH)) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (take) begin
          shift_d = shifted;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            wdata_d = shifted;
            waddr_d = BASE_ADDR + index_q;
          end
        end
      end
      WRITE: begin
        index_d = index_q + 32'd1;
        state_d = (index_q + 32'd1 == count_q) ? DONE : DATA;
      end
      default: state_d = state_q;
    endcase
    // Ready and write enable are registered off the next state so they line up with it.
    ready_d = (state_d == HDR) || (state_d == DATA);
    wen_d   = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HDR;
      bcnt_q  <= 2'd0;
      count_q <= 32'd0;
      shift_q <= 32'd0;
      index_q <= 32'd0;
      waddr_q <= BASE_ADDR;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      count_q <= count_d;
      shift_q <= shift_d;
      index_q <= index_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
    end
  end

  assign byte_ready = ready_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wen    = wen_q;
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule
